// File: rtl/uart_rx_if.sv
// Received-word handshake between the UART receiver and its consumer.
// A word is offered with valid and is consumed on a cycle where ready is high.
interface uart_rx_if;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic       rx_parity_err_o;
    logic       rx_frame_err_o;
    logic       rx_overrun_o;

    modport master (
        output rx_data_o,
        output rx_valid_o,
        output rx_parity_err_o,
        output rx_frame_err_o,
        output rx_overrun_o,
        input  rx_ready_i
    );

    modport slave (
        input  rx_data_o,
        input  rx_valid_o,
        input  rx_parity_err_o,
        input  rx_frame_err_o,
        input  rx_overrun_o,
        output rx_ready_i
    );
endinterface

// File: rtl/uart_rx.sv
// Configurable UART receiver: 5-8 data bits, optional even parity, 1 or 2 stop bits.
// Finished words are held on a valid/ready interface with an overrun pulse.
module uart_rx (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_i,
    input  logic        cfg_en_i,
    input  logic [15:0] cfg_div_i,
    input  logic        cfg_parity_en_i,
    input  logic [1:0]  cfg_bits_i,
    input  logic        cfg_stop_bits_i,
    output logic        busy_o,
    uart_rx_if.master   rx_if
);
    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA,
        PARITY,
        STOP_BIT_FIRST,
        STOP_BIT_LAST
    } state_t;

    state_t      state_q;
    logic        rx_meta_q;
    logic        rx_sync_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        par_q;
    logic        perr_q;
    logic        ferr_q;
    logic        done_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        perr_out_q;
    logic        ferr_out_q;
    logic        ovr_q;

    logic        full_tick_d;
    logic        half_tick_d;
    logic        last_bit_d;

    assign full_tick_d = (cnt_q == cfg_div_i);
    assign half_tick_d = (cnt_q == (cfg_div_i >> 1));
    assign last_bit_d  = (bit_idx_q == ({1'b0, cfg_bits_i} + 3'd4));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Frame FSM; the baud counter restarts at every state entry and every data bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            cnt_q  <= cnt_q + 16'd1;
            if (!cfg_en_i) begin
                state_q <= IDLE;
                cnt_q   <= 16'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        cnt_q <= 16'd0;
                        if (!rx_sync_q) begin
                            state_q   <= START_BIT;
                            bit_idx_q <= 3'd0;
                            shift_q   <= 8'd0;
                            par_q     <= 1'b0;
                            perr_q    <= 1'b0;
                            ferr_q    <= 1'b0;
                        end
                    end
                    START_BIT: begin
                        if (half_tick_d) begin
                            cnt_q   <= 16'd0;
                            state_q <= rx_sync_q ? IDLE : DATA;
                        end
                    end
                    DATA: begin
                        if (full_tick_d) begin
                            cnt_q              <= 16'd0;
                            shift_q[bit_idx_q] <= rx_sync_q;
                            par_q              <= par_q ^ rx_sync_q;
                            bit_idx_q          <= bit_idx_q + 3'd1;
                            if (last_bit_d)
                                state_q <= cfg_parity_en_i ? PARITY : STOP_BIT_FIRST;
                        end
                    end
                    PARITY: begin
                        if (full_tick_d) begin
                            cnt_q   <= 16'd0;
                            perr_q  <= par_q ^ rx_sync_q;
                            state_q <= STOP_BIT_FIRST;
                        end
                    end
                    STOP_BIT_FIRST: begin
                        if (full_tick_d) begin
                            cnt_q  <= 16'd0;
                            ferr_q <= ~rx_sync_q;
                            if (cfg_stop_bits_i) begin
                                state_q <= STOP_BIT_LAST;
                            end else begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    STOP_BIT_LAST: begin
                        if (full_tick_d) begin
                            cnt_q   <= 16'd0;
                            ferr_q  <= ferr_q | ~rx_sync_q;
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Output holding register: a completion overwrites any word still waiting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q     <= 8'd0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (done_q) begin
                data_q     <= shift_q;
                perr_out_q <= perr_q;
                ferr_out_q <= ferr_q;
                valid_q    <= 1'b1;
                ovr_q      <= valid_q & ~rx_if.rx_ready_i;
            end else if (rx_if.rx_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign busy_o                = (state_q != IDLE);
    assign rx_if.rx_data_o       = data_q;
    assign rx_if.rx_valid_o      = valid_q;
    assign rx_if.rx_parity_err_o = perr_out_q;
    assign rx_if.rx_frame_err_o  = ferr_out_q;
    assign rx_if.rx_overrun_o    = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames are bit-banged on rx_i, expected words queued
// when a frame is sent and compared when the receiver presents them.
module tb_uart_rx;
    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        en;
    logic [15:0] div;
    logic        pen;
    logic [1:0]  bits;
    logic        stop2;
    logic        busy;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   ovr_cnt = 0;

    always #5 clk = ~clk;

    uart_rx_if bus();

    uart_rx dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .rx_i            (rx),
        .cfg_en_i        (en),
        .cfg_div_i       (div),
        .cfg_parity_en_i (pen),
        .cfg_bits_i      (bits),
        .cfg_stop_bits_i (stop2),
        .busy_o          (busy),
        .rx_if           (bus)
    );

    always @(negedge clk)
        if (bus.rx_overrun_o === 1'b1) ovr_cnt++;

    task automatic drive_level(input logic b, input int cycles);
        rx = b;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input int nb, input logic p_en,
                              input logic pbit, input logic two_stop, input logic stop2_val);
        logic [7:0] m;
        exp_t       e;
        int         per;
        per   = int'(div) + 1;
        m     = data & ((8'd1 << nb) - 8'd1);
        bits  = 2'(nb - 5);
        pen   = p_en;
        stop2 = two_stop;
        e.d   = m;
        e.pe  = p_en & ((^m) ^ pbit);
        e.fe  = two_stop & ~stop2_val;
        sb.push_back(e);
        drive_level(1'b0, per);
        for (int i = 0; i < nb; i++) drive_level(m[i], per);
        if (p_en) drive_level(pbit, per);
        drive_level(1'b1, per);
        if (two_stop) begin
            if (stop2_val) begin
                drive_level(1'b1, per);
            end else begin
                drive_level(1'b0, int'(div) / 2 + 4);
                drive_level(1'b1, per - (int'(div) / 2 + 4));
            end
        end
        rx = 1'b1;
    endtask

    task automatic wait_valid(output bit to);
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (bus.rx_valid_o === 1'b1) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; en = 1'b1; div = 16'd15;
        pen = 1'b0; bits = 2'b11; stop2 = 1'b0; bus.rx_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({bus.rx_data_o, bus.rx_valid_o, bus.rx_parity_err_o, bus.rx_frame_err_o,
             bus.rx_overrun_o, busy} !== 13'd0)
            $display("FAIL reset_state got data=%h v=%b pe=%b fe=%b ov=%b busy=%b exp all 0",
                     bus.rx_data_o, bus.rx_valid_o, bus.rx_parity_err_o,
                     bus.rx_frame_err_o, bus.rx_overrun_o, busy);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        bit   to;
        exp_t e;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_valid(to);
        total_cnt++;
        if (to) $display("FAIL basic_timeout got no valid exp valid");
        else pass_cnt++;
        e = sb.pop_front();
        total_cnt++;
        if ({bus.rx_data_o, bus.rx_parity_err_o, bus.rx_frame_err_o} !== {e.d, e.pe, e.fe})
            $display("FAIL basic_word got %h/%b/%b exp %h/%b/%b", bus.rx_data_o,
                     bus.rx_parity_err_o, bus.rx_frame_err_o, e.d, e.pe, e.fe);
        else pass_cnt++;
        repeat (40) @(negedge clk);
        total_cnt++;
        if ({bus.rx_valid_o, bus.rx_data_o} !== {1'b1, e.d})
            $display("FAIL basic_hold got v=%b data=%h exp v=1 data=%h",
                     bus.rx_valid_o, bus.rx_data_o, e.d);
        else pass_cnt++;
        bus.rx_ready_i = 1'b1;
        @(negedge clk);
        bus.rx_ready_i = 1'b0;
        total_cnt++;
        if (bus.rx_valid_o !== 1'b0) $display("FAIL basic_accept got v=%b exp 0", bus.rx_valid_o);
        else pass_cnt++;
        drive_level(1'b1, 32);
    endtask

    task automatic test_parity();
        bit   to;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            send_frame(8'h03, 8, 1'b1, (k == 0) ? 1'b1 : 1'b0, 1'b0, 1'b1);
            wait_valid(to);
            total_cnt++;
            if (to) $display("FAIL parity_timeout_%0d got no valid exp valid", k);
            else pass_cnt++;
            e = sb.pop_front();
            total_cnt++;
            if ({bus.rx_data_o, bus.rx_parity_err_o, bus.rx_frame_err_o} !== {e.d, e.pe, e.fe})
                $display("FAIL parity_word_%0d got %h/%b/%b exp %h/%b/%b", k, bus.rx_data_o,
                         bus.rx_parity_err_o, bus.rx_frame_err_o, e.d, e.pe, e.fe);
            else pass_cnt++;
            bus.rx_ready_i = 1'b1;
            @(negedge clk);
            bus.rx_ready_i = 1'b0;
            drive_level(1'b1, 32);
        end
    endtask

    task automatic test_frame_err();
        bit   to;
        exp_t e;
        send_frame(8'h1F, 5, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_valid(to);
        total_cnt++;
        if (to) $display("FAIL frame_timeout got no valid exp valid");
        else pass_cnt++;
        e = sb.pop_front();
        total_cnt++;
        if ({bus.rx_data_o, bus.rx_parity_err_o, bus.rx_frame_err_o} !== {e.d, e.pe, e.fe})
            $display("FAIL frame_word got %h/%b/%b exp %h/%b/%b", bus.rx_data_o,
                     bus.rx_parity_err_o, bus.rx_frame_err_o, e.d, e.pe, e.fe);
        else pass_cnt++;
        bus.rx_ready_i = 1'b1;
        @(negedge clk);
        bus.rx_ready_i = 1'b0;
        drive_level(1'b1, 48);
        bits = 2'b11; stop2 = 1'b0;
    endtask

    task automatic test_glitch();
        drive_level(1'b0, 4);
        rx = 1'b1;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL glitch_start got busy=%b exp 1", busy);
        else pass_cnt++;
        drive_level(1'b1, 30);
        total_cnt++;
        if ({busy, bus.rx_valid_o} !== 2'b00)
            $display("FAIL glitch_reject got busy=%b v=%b exp 0/0", busy, bus.rx_valid_o);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        bit   to;
        exp_t e;
        ovr_cnt = 0;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_valid(to);
        total_cnt++;
        if (to) $display("FAIL overrun_timeout got no valid exp valid");
        else pass_cnt++;
        void'(sb.pop_front());
        e = sb.pop_front();
        repeat (4) @(negedge clk);
        total_cnt++;
        if ({bus.rx_valid_o, bus.rx_data_o} !== {1'b1, e.d})
            $display("FAIL overrun_word got v=%b data=%h exp v=1 data=%h",
                     bus.rx_valid_o, bus.rx_data_o, e.d);
        else pass_cnt++;
        total_cnt++;
        if (ovr_cnt !== 1) $display("FAIL overrun_pulse got %0d cycles exp 1", ovr_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit   to;
        exp_t e;
        drive_level(1'b0, 16);
        drive_level(1'b0, 16);
        drive_level(1'b1, 8);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL rstmid_busy got %b exp 1", busy);
        else pass_cnt++;
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({bus.rx_data_o, bus.rx_valid_o, bus.rx_parity_err_o, bus.rx_frame_err_o,
             bus.rx_overrun_o, busy} !== 13'd0)
            $display("FAIL rstmid_state got data=%h v=%b busy=%b exp all 0",
                     bus.rx_data_o, bus.rx_valid_o, busy);
        else pass_cnt++;
        rst = 1'b0;
        drive_level(1'b1, 32);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_valid(to);
        total_cnt++;
        if (to) $display("FAIL rstmid_timeout got no valid exp valid");
        else pass_cnt++;
        e = sb.pop_front();
        total_cnt++;
        if ({bus.rx_data_o, bus.rx_parity_err_o, bus.rx_frame_err_o} !== {e.d, e.pe, e.fe})
            $display("FAIL rstmid_word got %h/%b/%b exp %h/%b/%b", bus.rx_data_o,
                     bus.rx_parity_err_o, bus.rx_frame_err_o, e.d, e.pe, e.fe);
        else pass_cnt++;
    endtask

    task automatic test_cfg_en();
        exp_t e;
        bus.rx_ready_i = 1'b1;
        @(negedge clk);
        bus.rx_ready_i = 1'b0;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        e = sb.pop_front();
        drive_level(1'b0, 16);
        drive_level(1'b1, 8);
        en = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({busy, bus.rx_valid_o, bus.rx_data_o} !== {1'b0, 1'b1, e.d})
            $display("FAIL cfg_en_abort got busy=%b v=%b data=%h exp 0/1/%h",
                     busy, bus.rx_valid_o, bus.rx_data_o, e.d);
        else pass_cnt++;
        drive_level(1'b1, 160);
        en = 1'b1;
        drive_level(1'b1, 16);
        total_cnt++;
        if ({busy, bus.rx_valid_o, bus.rx_data_o} !== {1'b0, 1'b1, e.d})
            $display("FAIL cfg_en_discard got busy=%b v=%b data=%h exp 0/1/%h",
                     busy, bus.rx_valid_o, bus.rx_data_o, e.d);
        else pass_cnt++;
        bus.rx_ready_i = 1'b1;
        @(negedge clk);
        bus.rx_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        fork
            begin
                send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1);
                send_frame(8'h69, 8, 1'b0, 1'b0, 1'b0, 1'b1);
            end
            begin
                bit   to;
                exp_t e;
                for (int k = 0; k < 2; k++) begin
                    wait_valid(to);
                    total_cnt++;
                    if (to) $display("FAIL b2b_timeout_%0d got no valid exp valid", k);
                    else pass_cnt++;
                    e = sb.pop_front();
                    total_cnt++;
                    if ({bus.rx_data_o, bus.rx_parity_err_o, bus.rx_frame_err_o} !== {e.d, e.pe, e.fe})
                        $display("FAIL b2b_word_%0d got %h/%b/%b exp %h/%b/%b", k, bus.rx_data_o,
                                 bus.rx_parity_err_o, bus.rx_frame_err_o, e.d, e.pe, e.fe);
                    else pass_cnt++;
                    bus.rx_ready_i = 1'b1;
                    @(negedge clk);
                    bus.rx_ready_i = 1'b0;
                    @(negedge clk);
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_glitch();
        test_overrun();
        test_reset_mid();
        test_cfg_en();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have port clk_i, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port rx_i, input, 1, asynchronous serial line; idle high.
REQ-004 SHALL have port cfg_en_i, input, 1, receiver enable.
REQ-005 SHALL have port cfg_div_i, input, 16, bit period minus one, in clk_i cycles.
REQ-006 SHALL have port cfg_parity_en_i, input, 1, parity bit present (even parity).
REQ-007 SHALL have port cfg_bits_i, input, 2, data bits per frame = cfg_bits_i+5 (00=5 ... 11=8).
REQ-008 SHALL have port cfg_stop_bits_i, input, 1; 0 = one stop bit, 1 = two stop bits.
REQ-009 SHALL have port rx_data_o, output, 8, received word, LSB-first assembled, unused upper bits 0.
REQ-010 SHALL have port rx_valid_o, output, 1, rx_data_o and error flags valid.
REQ-011 SHALL have port rx_ready_i, input, 1, consumer accepts word.
REQ-012 SHALL have port rx_parity_err_o, output, 1, parity mismatch for word held; qualified by rx_valid_o.
REQ-013 SHALL have port rx_frame_err_o, output, 1, stop bit sampled low for word held; qualified by rx_valid_o.
REQ-014 SHALL have port rx_overrun_o, output, 1, one-cycle pulse when an unaccepted word is overwritten.
REQ-015 SHALL have port busy_o, output, 1, high whenever FSM not in IDLE.

Function
REQ-016 SHALL pass rx_i through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value.
REQ-017 SHALL implement states IDLE, START_BIT, DATA, PARITY, STOP_BIT_FIRST, STOP_BIT_LAST.
REQ-018 SHALL use one 16-bit baud counter cleared on each state entry; "full tick" = counter == cfg_div_i, "half tick" = counter == cfg_div_i>>1.
REQ-019 IDLE: on synchronized rx low with cfg_en_i high -> START_BIT.
REQ-020 START_BIT: at half tick, rx low -> DATA; rx high -> IDLE (glitch rejected, no output, no error).
REQ-021 DATA: sample at each full tick; bit k stored to rx_data bit k, k=0 first; after bit cfg_bits_i+4 -> PARITY if cfg_parity_en_i else STOP_BIT_FIRST.
REQ-022 PARITY: sample at full tick; error when XOR of data bits and parity bit is 1; -> STOP_BIT_FIRST.
REQ-023 STOP_BIT_FIRST: sample at full tick; low sets frame error; -> STOP_BIT_LAST if cfg_stop_bits_i else IDLE with word completion.
REQ-024 STOP_BIT_LAST: sample at full tick; low sets frame error; -> IDLE with word completion.
REQ-025 Word completion SHALL load rx_data_o, rx_parity_err_o, rx_frame_err_o and set rx_valid_o on the next clock edge (1-cycle latency from final stop sample).
REQ-026 rx_valid_o SHALL stay high, outputs stable, until a cycle with rx_ready_i high; cleared on that edge.
REQ-027 Completion while rx_valid_o high and rx_ready_i low SHALL overwrite outputs, keep rx_valid_o high, pulse rx_overrun_o for one cycle.
REQ-028 Completion in same cycle as rx_ready_i with rx_valid_o high SHALL load new word, keep rx_valid_o high, no overrun.
REQ-029 Parity error flag SHALL be 0 when cfg_parity_en_i is 0; frame error accumulates over both stop bits.
REQ-030 cfg_en_i low SHALL force FSM to IDLE next cycle, discard partial frame; held rx_valid_o word retained.
REQ-031 Configuration inputs SHALL be treated as static while busy_o is high; changes mid-frame are undefined.

Reset
REQ-032 rst_i high SHALL set FSM IDLE, counters 0, synchronizer 1, rx_data_o 0x00, rx_valid_o 0, all error outputs 0, busy_o 0, including mid-frame.

Verification
REQ-033 div=15, 8 bits, no parity, 1 stop, frame 0xA5 -> rx_data_o=0xA5, rx_valid_o high until rx_ready_i, errors 0.
REQ-034 div=15, 8 bits, parity on, 0x03 with parity bit 1 -> rx_data_o=0x03, rx_parity_err_o=1; with parity bit 0 -> err 0.
REQ-035 5 bits, two stop bits, second stop driven low, data 0x1F -> rx_data_o=0x1F, rx_frame_err_o=1.
REQ-036 rx_i low for 4 cycles with div=15 -> FSM returns IDLE, rx_valid_o stays 0.
REQ-037 two frames 0x11, 0x22 with rx_ready_i held low -> rx_data_o=0x22, rx_overrun_o single-cycle pulse.
REQ-038 rst_i asserted mid-DATA -> all outputs at reset values next cycle; next clean frame 0x5A received correctly.
